fifo_word_packer: RTL
=====================

// Module: fifo_word_packer
// PURPOSE
// Downstream consumer of the team's sync FIFO. Pops WIDTH-bit words and packs RATIO consecutive words
// into one WIDTH*RATIO-bit word. Presents the packed word on a valid/ready output.
// A flush request emits a partial word and marks it last, so packet tails are never stranded in the packer.
// PARAMETERS
// WIDTH  8  bits per FIFO word
// RATIO  4  FIFO words per output word (>=2)
// PORTS
// clk         in   1              clock, all logic on posedge
// rst         in   1              reset, synchronous, active-high
// fifo_empty  in   1              FIFO empty flag
// fifo_data   in   WIDTH          FIFO read data, valid the cycle after an accepted read
// fifo_rd     out  1              FIFO read strobe
// flush       in   1              single-cycle request: emit partial word
// flush_done  out  1              single-cycle pulse: flush finished
// out_valid   out  1              packed word available
// out_ready   in   1              consumer accepts when out_valid & out_ready
// out_data    out  WIDTH*RATIO    packed word, first-read word in bits [WIDTH-1:0]
// out_count   out  $clog2(RATIO+1) number of valid words in out_data (1..RATIO)
// out_last    out  1              word was produced by a flush
// busy        out  1              state!=FILL, or accumulator/in-flight non-zero
// BEHAVIOUR
// - Reset (rst=1 at posedge): fifo_rd=0, flush_done=0, out_valid=0, out_data=0, out_count=0, out_last=0, busy=0.
//   Also clears acc_count, inflight and the accumulator; state=FILL. A read in flight is discarded.
// - Storage: accumulator (RATIO slots + acc_count) and output register. Output register holds while stalled.
// - fifo_rd is combinational: !rst & state==FILL & !fifo_empty & (acc_count+inflight < RATIO).
//   fifo_rd is never high while fifo_empty=1.
// - inflight is a 1-bit register, set to fifo_rd each cycle.
//   When inflight=1, fifo_data is written to slot acc_count and acc_count increments.
// - Transfer: when acc_count==RATIO and (!out_valid | out_ready):
//   - the accumulator is copied to out_data; out_count=RATIO, out_last=0, out_valid=1;
//   - acc_count=0, and a word landing on that same edge goes to slot 0 (acc_count=1).
// - Latency: out_valid rises 2 cycles after the cycle in which the RATIO-th word is on fifo_data,
//   provided the output slot is free.
// - Output handshake: out_valid drops after accept unless a new transfer occurs on the same edge.
//   out_data, out_count and out_last are stable while out_valid & !out_ready.
// - FSM:
//   - FILL: flush=1 -> DRAIN. A flush pulse in any other state is ignored.
//   - DRAIN: no reads; wait until inflight==0, then go to EMIT.
//   - EMIT, acc_count==0: pulse flush_done, go to FILL.
//   - EMIT, acc_count>0: when (!out_valid | out_ready), load out_data with unused slots zeroed,
//     out_count=acc_count, out_last=1 (out_last=0 if acc_count==RATIO); acc_count=0;
//     pulse flush_done on that edge; go to FILL.
//   - Full-accumulator transfers also proceed normally in DRAIN.
// - Arithmetic: acc_count range 0..RATIO and acc_count+inflight never exceeds RATIO.
//   No word is dropped or duplicated.
// - rst mid-packet: the partial word is discarded; no output is produced for it.
// TESTING (WIDTH=8, RATIO=4)
// 1. Push 0x11,0x22,0x33,0x44, out_ready=1 -> one output: out_data=0x44332211, out_count=4, out_last=0; 4 fifo_rd pulses.
// 2. out_ready=0, push 0x01..0x08 -> out_data=0x04030201 held stable; acc fills 0x08070605; fifo_rd stops.
//    Raise out_ready -> 0x08070605 follows; no loss.
// 3. Push 0xA1,0xA2,0xA3, then flush -> out_data=0x00A3A2A1, out_count=3, out_last=1; one flush_done pulse.
// 4. Flush with FIFO empty and packer idle -> flush_done within 3 cycles, out_valid stays 0.
// 5. Random fifo_empty gaps and out_ready stalls over 1000 words -> fifo_rd&fifo_empty never 1;
//    output order matches the scoreboard.
// 6. rst after 2 of 4 words -> all outputs at reset values next cycle; next 4 words form one clean packet.

Source files
------------

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops WIDTH-bit FIFO words and packs RATIO of them into one valid/ready output word, with flush.
module fifo_word_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    input  logic [WIDTH-1:0]           fifo_data,
    output logic                       fifo_rd,
    input  logic                       flush,
    output logic                       flush_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH*RATIO-1:0]     out_data,
    output logic [$clog2(RATIO+1)-1:0] out_count,
    output logic                       out_last,
    output logic                       busy
);
    localparam int CW = $clog2(RATIO + 1);
    localparam int IW = $clog2(RATIO);
    typedef enum logic [1:0] {FILL, DRAIN, EMIT} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] acc [RATIO];
    logic [CW-1:0] acc_count, base;
    logic [WIDTH*RATIO-1:0] packed_w;
    logic inflight, free, full, load, done_nx;
    assign full = acc_count == CW'(RATIO);
    assign free = !out_valid || out_ready;
    assign load = free && (full || (state == EMIT && acc_count != '0));
    // a word landing on the same edge as a load restarts the accumulator at slot 0
    assign base = load ? '0 : acc_count;
    assign fifo_rd = !rst && state == FILL && !fifo_empty && (int'(acc_count) + int'(inflight) < RATIO);
    assign busy = state != FILL || acc_count != '0 || inflight;
    always_comb begin
        packed_w = '0;
        for (int i = 0; i < RATIO; i++)
            packed_w[i*WIDTH +: WIDTH] = (i < int'(acc_count)) ? acc[i] : '0;
    end
    always_comb begin
        state_nx = state;
        done_nx = 1'b0;
        case (state)
            FILL:  state_nx = flush ? DRAIN : FILL;
            DRAIN: state_nx = inflight ? DRAIN : EMIT;
            EMIT: begin
                done_nx = acc_count == '0 || free;
                state_nx = done_nx ? FILL : EMIT;
            end
            default: state_nx = FILL;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            inflight <= 1'b0;
            acc_count <= '0;
            flush_done <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_count <= '0;
            out_last <= 1'b0;
            for (int i = 0; i < RATIO; i++)
                acc[i] <= '0;
        end else begin
            state <= state_nx;
            flush_done <= done_nx;
            inflight <= fifo_rd;
            if (load) begin
                out_data <= packed_w;
                out_count <= acc_count;
                out_last <= state == EMIT && !full;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (inflight) begin
                acc[base[IW-1:0]] <= fifo_data;
                acc_count <= base + CW'(1);
            end else begin
                acc_count <= base;
            end
        end
    end
endmodule
